// File: rtl/seg_scan_if.sv
// Bundles the scan controller's control inputs and display outputs.
// The master side drives en/load/din. The slave side (the controller) drives the select and segment lines.
interface seg_scan_if;
    logic        en;
    logic        load;
    logic [31:0] din;
    logic        sel_a;
    logic        sel_b;
    logic        sel_c;
    logic [6:0]  seg;
    logic        frame_tick;

    modport master (
        output en, load, din,
        input  sel_a, sel_b, sel_c, seg, frame_tick
    );

    modport slave (
        input  en, load, din,
        output sel_a, sel_b, sel_c, seg, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit 7-segment scan controller with a programmable slot length.
// Optional leading-zero blanking is enabled by defining SEG_LEAD_ZERO_BLANK_EN.
module seg_scan_ctrl #(
    parameter int CLK_DIV = 50000,
    parameter int CNT_W   = 20
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [31:0]      shadow;
    logic [6:0]       seg_q;
    logic             frame_q;
    logic             tick;
    logic [3:0]       nib;
    logic             blank;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'h3F;
            4'h1: font = 7'h06;
            4'h2: font = 7'h5B;
            4'h3: font = 7'h4F;
            4'h4: font = 7'h66;
            4'h5: font = 7'h6D;
            4'h6: font = 7'h7D;
            4'h7: font = 7'h07;
            4'h8: font = 7'h7F;
            4'h9: font = 7'h6F;
            4'hA: font = 7'h77;
            4'hB: font = 7'h7C;
            4'hC: font = 7'h39;
            4'hD: font = 7'h5E;
            4'hE: font = 7'h79;
            default: font = 7'h71;
        endcase
    endfunction

    assign tick = bus.en && (cnt == CNT_LAST);
    assign nib  = shadow[{idx, 2'b00} +: 4];

`ifdef SEG_LEAD_ZERO_BLANK_EN
    // Digit k is blank when it and every higher nibble are zero; digit 0 always shows.
    logic [7:0] lz_mask;
    always_comb begin
        lz_mask = 8'h00;
        for (int k = 1; k < 8; k++) begin
            lz_mask[k] = ((shadow >> (4 * k)) == 32'd0);
        end
    end
    assign blank = lz_mask[idx];
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= 3'd0;
            shadow  <= 32'h0;
            seg_q   <= 7'h00;
            frame_q <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow <= bus.din;
            end
            if (bus.en) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
            if (tick) begin
                idx <= idx + 3'd1;
            end
            frame_q <= tick && (idx == 3'd7);
            // Uses pre-edge idx/shadow, so seg trails an index change or load by one clock.
            seg_q   <= (bus.en && !blank) ? font(nib) : 7'h00;
        end
    end

    assign bus.sel_a      = idx[2];
    assign bus.sel_b      = idx[1];
    assign bus.sel_c      = idx[0];
    assign bus.seg        = seg_q;
    assign bus.frame_tick = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: two instances (CLK_DIV=4 and CLK_DIV=1) share one random stimulus stream.
// The reference model tracks enabled-cycle count and derives index, frame and glyph arithmetically.
module tb_seg_scan_ctrl;

    typedef struct packed {
        logic [2:0] sel;
        logic [6:0] seg;
        logic       ft;
    } obs_t;

    typedef struct packed {
        obs_t d4;
        obs_t d1;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_if if4 ();
    seg_scan_if if1 ();

    seg_scan_ctrl #(.CLK_DIV(4), .CNT_W(3)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    seg_scan_ctrl #(.CLK_DIV(1), .CNT_W(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    logic [6:0] font_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          errors = 0;
    int          checks = 0;
    exp_t        q[$];
    longint      p  [2];
    logic [31:0] sh [2];
    longint      dv [2] = '{4, 1};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic obs_t get4();
        return {if4.sel_a, if4.sel_b, if4.sel_c, if4.seg, if4.frame_tick};
    endfunction

    function automatic obs_t get1();
        return {if1.sel_a, if1.sel_b, if1.sel_c, if1.seg, if1.frame_tick};
    endfunction

    function automatic logic [6:0] glyph(input logic [31:0] s, input int k);
        logic [31:0] t;
        t = s >> (4 * k);
`ifdef SEG_LEAD_ZERO_BLANK_EN
        if (k > 0 && t == 32'd0) return 7'h00;
`endif
        return font_tbl[t[3:0]];
    endfunction

    task automatic set_in(input logic e, input logic l, input logic [31:0] d);
        if4.en = e; if4.load = l; if4.din = d;
        if1.en = e; if1.load = l; if1.din = d;
    endtask

    // Expected outputs after the coming rising edge, given the inputs just applied.
    task automatic model_edge(input logic e, input logic l, input logic [31:0] d);
        obs_t o [2];
        for (int i = 0; i < 2; i++) begin
            int ib;
            ib = int'((p[i] / dv[i]) % 8);
            o[i].seg = e ? glyph(sh[i], ib) : 7'h00;
            if (e) p[i]++;
            o[i].ft  = e && (p[i] % (8 * dv[i]) == 0);
            o[i].sel = 3'((p[i] / dv[i]) % 8);
            if (l) sh[i] = d;
        end
        q.push_back({o[0], o[1]});
    endtask

    task automatic drive(input logic e, input logic l, input logic [31:0] d);
        @(negedge clk);
        rst = 1'b0;
        set_in(e, l, d);
        model_edge(e, l, d);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_sel4", 32'(get4().sel), 32'h0);
        check("rst_seg4", 32'(get4().seg), 32'h0);
        check("rst_ft4",  32'(get4().ft),  32'h0);
        check("rst_sel1", 32'(get1().sel), 32'h0);
        check("rst_seg1", 32'(get1().seg), 32'h0);
        check("rst_ft1",  32'(get1().ft),  32'h0);
        p  = '{0, 0};
        sh = '{32'h0, 32'h0};
        q.push_back('0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("sel4", 32'(get4().sel), 32'(x.d4.sel));
                check("seg4", 32'(get4().seg), 32'(x.d4.seg));
                check("ft4",  32'(get4().ft),  32'(x.d4.ft));
                check("sel1", 32'(get1().sel), 32'(x.d1.sel));
                check("seg1", 32'(get1().seg), 32'(x.d1.seg));
                check("ft1",  32'(get1().ft),  32'(x.d1.ft));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic reached;
        rst = 1'b1;
        set_in(1'b0, 1'b0, 32'h0);
        p  = '{0, 0};
        sh = '{32'h0, 32'h0};
        #1;
        check("init_sel4", 32'(get4().sel), 32'h0);
        check("init_seg4", 32'(get4().seg), 32'h0);
        check("init_ft4",  32'(get4().ft),  32'h0);
        check("init_seg1", 32'(get1().seg), 32'h0);

        drive(1'b1, 1'b1, 32'h7654_3210);
        repeat (40) drive(1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'hFEDC_BA98);
        repeat (40) drive(1'b1, 1'b0, 32'h0);
        repeat (10) drive(1'b0, 1'b0, 32'h0);
        repeat (20) drive(1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h0000_0000);
        repeat (40) drive(1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h0001_2000);
        repeat (40) drive(1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h0000_00A5);
        repeat (10) drive(1'b1, 1'b0, 32'h0);

        reached = 1'b0;
        for (int n = 0; n < 64 && !reached; n++) begin
            if ((p[0] / 4) % 8 == 5) reached = 1'b1;
            else drive(1'b1, 1'b0, 32'h0);
        end
        check("reach_idx5", 32'(reached), 32'h1);
        reset_mid();
        repeat (12) drive(1'b1, 1'b0, 32'h0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) reset_mid();
            else drive($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, $urandom);
        end

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
